// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each requester keeps the grant for up to its
// effective weight in consecutive cycles, then priority rotates past it.
module weighted_rr_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_sigs,
    input  logic [N*WEIGHT_W-1:0] weights,
    output logic [N-1:0]          grant_sigs,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    owner_reg, owner_next;
    logic [WEIGHT_W-1:0] credit_reg, credit_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;

    logic [WEIGHT_W-1:0] w_eff [N];
    logic [IDX_W-1:0]    owner_inc;
    logic [IDX_W-1:0]    cand;

    // A zero weight is promoted to one so no requester can be starved.
    for (genvar gi = 0; gi < N; gi++) begin : g_weff
        assign w_eff[gi] = (weights[gi*WEIGHT_W +: WEIGHT_W] == '0)
                         ? WEIGHT_W'(1) : weights[gi*WEIGHT_W +: WEIGHT_W];
    end

    // First set bit of v, scanning upward from p and wrapping mod N.
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] v,
                                             input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] r;
        int               idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N) idx = idx - N;
            if (v[idx]) r = IDX_W'(idx);
        end
        return r;
    endfunction

    assign owner_inc = (owner_reg == IDX_W'(N - 1)) ? '0 : owner_reg + IDX_W'(1);
    assign cand      = sel(req_sigs, (state_reg == IDLE) ? ptr_reg : owner_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            credit_reg <= '0;
            ptr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            credit_reg <= credit_next;
            ptr_reg    <= ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        credit_next = credit_reg;
        ptr_next    = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req_sigs) begin
                    owner_next  = cand;
                    credit_next = w_eff[cand] - WEIGHT_W'(1);
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (req_sigs[owner_reg] && (credit_reg != '0)) begin
                    credit_next = credit_reg - WEIGHT_W'(1);
                end else begin
                    // Hand over without an idle bubble; leftover credit is discarded.
                    ptr_next = owner_inc;
                    if (|req_sigs) begin
                        owner_next  = cand;
                        credit_next = w_eff[cand] - WEIGHT_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_valid = (state_reg == BUSY);
    assign grant_sigs  = grant_valid ? ({{(N-1){1'b0}}, 1'b1} << owner_reg) : '0;
    assign grant_idx   = grant_valid ? owner_reg : '0;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios with literal grant
// expectations plus a turn-based reference model compared every cycle.
module tb_weighted_rr_arbiter;

    localparam int N = 4;
    localparam int WW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_sigs;
    logic [N*WW-1:0] weights;
    logic [N-1:0]  grant_sigs;
    logic          grant_valid;
    logic [1:0]    grant_idx;

    int total = 0;
    int bad   = 0;

    // Model: current turn holder (-1 = nobody), cycles used in this turn,
    // length of this turn captured at its start, and next search start.
    int m_cur  = -1;
    int m_used = 0;
    int m_len  = 0;
    int m_ptr  = 0;

    weighted_rr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
        .clk(clk),
        .rst(rst),
        .req_sigs(req_sigs),
        .weights(weights),
        .grant_sigs(grant_sigs),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int turn_len(input int i);
        int w;
        w = int'(weights[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic start_turn();
        m_cur  = first_from(req_sigs, m_ptr);
        m_used = 1;
        m_len  = turn_len(m_cur);
    endtask

    task automatic model_step();
        if (!rst) begin
            m_cur = -1;
            m_ptr = 0;
        end else if (m_cur < 0) begin
            if (req_sigs != 0) start_turn();
        end else if (req_sigs[m_cur] && m_used < m_len) begin
            m_used++;
        end else begin
            m_ptr = (m_cur + 1) % N;
            if (req_sigs != 0) start_turn();
            else m_cur = -1;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("cmp_grant_sigs", 32'(grant_sigs), (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
        chk("cmp_grant_idx", 32'(grant_idx), (m_cur < 0) ? 32'd0 : 32'(m_cur));
        chk("cmp_grant_valid", 32'(grant_valid), (m_cur < 0) ? 32'd0 : 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_expect(input string name, input logic [N-1:0] exp_seq [$]);
        foreach (exp_seq[i]) begin
            tick();
            chk(name, 32'(grant_sigs), 32'(exp_seq[i]));
            $display("%s step %0d: req=%b grant=%b idx=%0d", name, i, req_sigs, grant_sigs, grant_idx);
        end
    endtask

    initial begin
        rst      = 1'b0;
        req_sigs = 4'b1111;
        weights  = {4'd1, 4'd1, 4'd1, 4'd1};

        // Reset held with all requesting
        tick();
        tick();
        chk("reset_grant", 32'(grant_sigs), 32'd0);
        chk("reset_idx", 32'(grant_idx), 32'd0);
        rst = 1'b1;
        run_expect("release", '{4'b0001});

        // Unit weights rotate one per cycle
        run_expect("rotate", '{4'b0010, 4'b0100, 4'b1000, 4'b0001});

        // Weights idx3..0 = 3,1,2,1
        weights = {4'd3, 4'd1, 4'd2, 4'd1};
        run_expect("weighted", '{4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000,
                                 4'b1000, 4'b0001, 4'b0010, 4'b0010});

        // Heavy idx1 drops request mid-burst
        weights  = {4'd1, 4'd1, 4'd8, 4'd1};
        req_sigs = 4'b1011;
        run_expect("early_drop_a", '{4'b1000, 4'b0001, 4'b0010, 4'b0010});
        req_sigs = 4'b1001;
        run_expect("early_drop_b", '{4'b1000});

        // Sole requester keeps the grant across reloads
        weights  = {4'd1, 4'd2, 4'd1, 4'd1};
        req_sigs = 4'b0100;
        run_expect("sole", '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100});
        req_sigs = 4'b0000;
        run_expect("sole_release", '{4'b0000});
        chk("idle_idx", 32'(grant_idx), 32'd0);
        chk("idle_valid", 32'(grant_valid), 32'd0);

        // Zero weights alternate; reset mid-run clears and rewinds the pointer
        weights  = '0;
        req_sigs = 4'b1001;
        run_expect("zero_w", '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000});
        #2 rst = 1'b0;
        #1 chk("async_reset_grant", 32'(grant_sigs), 32'd0);
        chk("async_reset_valid", 32'(grant_valid), 32'd0);
        run_expect("in_reset", '{4'b0000});
        rst = 1'b1;
        run_expect("ptr_rewound", '{4'b0001, 4'b1000});

        // Randomised traffic checked against the model only
        for (int c = 0; c < 400; c++) begin
            if ((c % 3) == 0) req_sigs = 4'($urandom_range(0, 15));
            if ((c % 7) == 0) weights = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
